// File: rtl/bcd_pkg.sv
// bcd_pkg: definitions shared by the sequential binary-to-BCD converter.
// Holds the converter state encoding, the BCD digit width, the saturation
// digit value, and a constant function that gives the largest value a
// given number of decimal digits can show.
package bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  // 10^n - 1, evaluated at 64 bits so the widest digit count still fits.
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// bcd_dabble_digit: combinational double-dabble digit adjust.
// A digit of 5 or more gets +3 before the next left shift, so that the
// shift carries correctly into the next decimal digit. Any carry out of
// the 4-bit sum is dropped on purpose.
// Ports:
//   digit_i  in  4  working BCD digit
//   digit_o  out 4  adjusted digit
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Add 3 to any digit that would overflow past 9 after doubling.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double dabble),
// one input bit per clock, with start/busy/done handshake.
// Values above 10^DIGITS-1 saturate to all nines and raise overflow.
// Optional feature: define BIN2BCD_SIGNED_EN to treat `binary` as two's
// complement; the magnitude is converted and `negative` reports the sign.
// Without it `binary` is unsigned and `negative` stays 0.
// Ports:
//   clock     in   1           rising-edge clock
//   reset     in   1           synchronous active-high reset
//   start     in   1           conversion request, sampled when not busy
//   binary    in   BIN_W       value captured on the accepting edge
//   busy      out  1           conversion in progress
//   done      out  1           one-cycle result pulse
//   decimal   out  4*DIGITS    packed BCD, digit 0 in [3:0]
//   overflow  out  1           value exceeded 10^DIGITS-1
//   negative  out  1           sign of the converted value
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              binary,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] decimal,
  output logic                          overflow,
  output logic                          negative
);

  localparam int          DEC_W   = BCD_DIGIT_W * DIGITS;
  localparam int          WORK_W  = BIN_W + DEC_W;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [63:0] DEC_MAX = pow10_minus1(DIGITS);
  localparam logic [DEC_W-1:0] DEC_SAT = {DIGITS{BCD_NINE}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic               range_q, range_d;
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic               ovf_q, ovf_d;
  logic               neg_q, neg_d;

  logic [BIN_W-1:0]   mag_s;
  logic               sign_s;
  logic [63:0]        mag_ext_s;
  logic [DEC_W-1:0]   adj_s;
  logic [WORK_W-1:0]  shifted_s;

`ifdef BIN2BCD_SIGNED_EN
  // Negation is done at BIN_W bits so the most negative value yields
  // its correct unsigned magnitude 2^(BIN_W-1).
  assign sign_s = binary[BIN_W-1];
  assign mag_s  = sign_s ? (~binary + BIN_W'(1)) : binary;
`else
  assign sign_s = 1'b0;
  assign mag_s  = binary;
`endif

  assign mag_ext_s = 64'(mag_s);

  // One adjust cell per working digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i (work_q[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (adj_s[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits and remaining binary bits shift left as one register;
  // the top digit's carry falls off and is covered by the range flag.
  assign shifted_s = {adj_s[DEC_W-2:0], work_q[BIN_W-1:0], 1'b0};

  // Next-state logic for the FSM, datapath and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    range_d = range_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    dec_d   = dec_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = WORK_W'(mag_s);
          cnt_d   = CNT_W'(BIN_W);
          range_d = (mag_ext_s > DEC_MAX);
          sign_d  = sign_s;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shifted_s;
        cnt_d  = cnt_q - CNT_W'(1);
        // Last shift: publish the result on this same edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          dec_d   = range_q ? DEC_SAT : shifted_s[WORK_W-1:BIN_W];
          ovf_d   = range_q;
          neg_d   = sign_q;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      range_q <= 1'b0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      dec_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      range_q <= range_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  assign decimal  = dec_q;
  assign overflow = ovf_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three instances (16/5, 16/4, 8/3)
// driven by one directed sequence. Honours BIN2BCD_SIGNED_EN.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b, start_c;
  logic [15:0] bin_a, bin_b;
  logic [7:0]  bin_c;
  logic        busy_a, done_a, ov_a, neg_a;
  logic        busy_b, done_b, ov_b, neg_b;
  logic        busy_c, done_c, ov_c, neg_c;
  logic [19:0] dec_a;
  logic [15:0] dec_b;
  logic [11:0] dec_c;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_a (
    .clock(clk), .reset(rst), .start(start_a), .binary(bin_a), .busy(busy_a),
    .done(done_a), .decimal(dec_a), .overflow(ov_a), .negative(neg_a));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u_b (
    .clock(clk), .reset(rst), .start(start_b), .binary(bin_b), .busy(busy_b),
    .done(done_b), .decimal(dec_b), .overflow(ov_b), .negative(neg_b));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_c (
    .clock(clk), .reset(rst), .start(start_c), .binary(bin_c), .busy(busy_c),
    .done(done_c), .decimal(dec_c), .overflow(ov_c), .negative(neg_c));

  logic        o_busy, o_done, o_ov, o_neg;
  logic [63:0] o_dec;

  always_comb begin
    o_busy = busy_a; o_done = done_a; o_ov = ov_a; o_neg = neg_a; o_dec = 64'(dec_a);
    case (sel)
      1: begin o_busy = busy_b; o_done = done_b; o_ov = ov_b; o_neg = neg_b; o_dec = 64'(dec_b); end
      2: begin o_busy = busy_c; o_done = done_c; o_ov = ov_c; o_neg = neg_c; o_dec = 64'(dec_c); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input int s, input logic [31:0] v, input logic [63:0] exp_dec,
                          input logic exp_ov, input logic exp_neg, input int lat);
    int n;
    sel = s;
    @(negedge clk);
    case (s)
      0: begin bin_a = v[15:0]; start_a = 1'b1; end
      1: begin bin_b = v[15:0]; start_b = 1'b1; end
      default: begin bin_c = v[7:0]; start_c = 1'b1; end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = 16'hDEAD; bin_b = 16'hBEEF; bin_c = 8'h5A;
    chk("busy_after_accept", 64'(o_busy), 64'd1);
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("decimal", o_dec, exp_dec);
    chk("overflow", 64'(o_ov), 64'(exp_ov));
    chk("negative", 64'(o_neg), 64'(exp_neg));
    chk("busy_in_done", 64'(o_busy), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("decimal_hold", o_dec, exp_dec);
  endtask

  initial begin
    int bad;
    logic [7:0]  u;
    logic [7:0]  mag;
    logic        nexp;
    logic [63:0] e;

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = 16'd0; bin_b = 16'd0; bin_c = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_decimal", 64'(dec_a), 64'd0);
    chk("rst_overflow", 64'(ov_a), 64'd0);
    chk("rst_negative", 64'(neg_a), 64'd0);
    rst = 1'b0;

    // 16-bit / 5-digit basics
    run_conv(0, 32'd0, 64'h00000, 1'b0, 1'b0, 16);
`ifdef BIN2BCD_SIGNED_EN
    run_conv(0, 32'hFFFF, 64'h00001, 1'b0, 1'b1, 16);
    run_conv(0, 32'h8000, 64'h32768, 1'b0, 1'b1, 16);
`else
    run_conv(0, 32'd65535, 64'h65535, 1'b0, 1'b0, 16);
    run_conv(0, 32'h8000, 64'h32768, 1'b0, 1'b0, 16);
`endif
    run_conv(0, 32'd1000, 64'h01000, 1'b0, 1'b0, 16);

    // 16-bit / 4-digit saturation boundary
    run_conv(1, 32'd9999, 64'h9999, 1'b0, 1'b0, 16);
    run_conv(1, 32'd10000, 64'h9999, 1'b1, 1'b0, 16);
    run_conv(1, 32'd12345, 64'h9999, 1'b1, 1'b0, 16);

    // start held high: back-to-back conversions, mid-conversion start ignored
    sel = 0;
    @(negedge clk);
    bin_a = 16'd1234; start_a = 1'b1;
    @(negedge clk);
    bin_a = 16'd4321;
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (i == 16 || i == 33) begin
        if (done_a !== 1'b1 || busy_a !== 1'b0) bad++;
      end else begin
        if (done_a !== 1'b0 || busy_a !== 1'b1) bad++;
      end
      if (i == 16) chk("hs_first", 64'(dec_a), 64'h01234);
      if (i == 33) begin
        chk("hs_second", 64'(dec_a), 64'h04321);
        start_a = 1'b0;
      end
    end
    chk("hs_busy_done_pattern", 64'(bad), 64'd0);
    @(posedge clk); #1;
    chk("hs_idle_after", 64'(busy_a), 64'd0);

    // reset during SHIFT aborts without done
    @(negedge clk);
    bin_a = 16'd500; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_decimal", 64'(dec_a), 64'd0);
    chk("abort_overflow_b", 64'(ov_b), 64'd0);
    chk("abort_decimal_b", 64'(dec_b), 64'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a !== 1'b0) bad++;
    end
    chk("abort_no_done", 64'(bad), 64'd0);
    run_conv(0, 32'd42, 64'h00042, 1'b0, 1'b0, 16);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; start_a = 1'b1; bin_a = 16'd7;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    chk("reset_beats_start", 64'(busy_a), 64'd0);

    // 8-bit / 3-digit exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      u = 8'(i);
      mag = u;
      nexp = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      if (u[7]) begin
        mag = 8'(256 - i);
        nexp = 1'b1;
      end
`endif
      e = (64'(mag / 8'd100) << 8) | (64'((mag / 8'd10) % 8'd10) << 4) | 64'(mag % 8'd10);
      run_conv(2, 32'(i), e, 1'b0, nexp, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
